round_sequencer: RTL
====================

// Module: round_sequencer
// PURPOSE
//   Sequences the ASCON permutation p^N over the combinational round datapath (constant add -> substitution ->
//   diffusion). Sits directly upstream of the constant-addition stage: drives its round index and the
//   registered 320-bit state, and captures the round output back each cycle.
//   Runs N rounds (6, 8 or 12 typical), then presents the result with a valid/ready handshake.
// PARAMETERS
//   MAX_ROUNDS      12   length of ascon_pkg::ROUND_CONSTANTS; last round index is MAX_ROUNDS-1
//   DEFAULT_ROUNDS  12   round count used when i_rounds is out of range (0 or > MAX_ROUNDS)
// PORTS
//   clock          in   1             single clock, rising edge
//   reset_n        in   1             asynchronous, active-low reset
//   i_start        in   1             request: load i_state and run i_rounds rounds
//   i_rounds       in   4             number of rounds N for this run, sampled with i_start
//   i_state        in   t_state_array initial permutation state, sampled with i_start
//   o_ready        out  1             sequencer idle, i_start accepted this cycle
//   o_round        out  4             round index to constant-addition stage
//   o_state        out  t_state_array state register, to datapath input and result output
//   i_round_state  in   t_state_array state after one full round (diffusion output)
//   o_valid        out  1             o_state holds finished p^N result
//   i_ready        in   1             consumer accepts result when o_valid && i_ready
//   o_busy         out  1             rounds in progress
// BEHAVIOUR
//   Reset (reset_n=0, async, any state/time): FSM=IDLE, state reg=0 (all 5 words), o_round=0, o_valid=0,
//     o_busy=0, o_ready=1 once IDLE. Reset mid-run aborts; no result is ever presented for aborted run.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: o_ready=1. On edge with i_start=1: state reg <= i_state; Neff = i_rounds if 1..MAX_ROUNDS else
//     DEFAULT_ROUNDS; o_round <= MAX_ROUNDS-Neff; -> RUN. i_start=0: hold, state reg unchanged.
//   RUN: o_busy=1, o_ready=0. Every edge: state reg <= i_round_state. If o_round==MAX_ROUNDS-1 -> DONE,
//     o_round <= 0; else o_round <= o_round+1. Exactly Neff captures, o_round steps 12-Neff .. 11.
//   DONE: o_valid=1, o_state stable. Edge with i_ready=1 -> IDLE, o_valid<=0 (state reg retained).
//     i_ready=0: hold indefinitely, o_state and o_valid unchanged.
//   Latency: start accepted at edge 0 -> o_valid high after edge Neff (Neff cycles); throughput one
//     permutation per Neff+2 cycles with i_ready tied high (IDLE cycle needed to accept next start).
//   i_start while not in IDLE is ignored (not queued); i_rounds/i_state only sampled on the accept edge.
//   o_round is 4-bit unsigned; never exceeds MAX_ROUNDS-1; no wrap beyond 11.
//   Outputs registered; o_ready/o_valid/o_busy decoded directly from FSM register (glitch-free).
//   Result transfer and new start cannot coincide (o_ready=0 in DONE).
//   Unknown FSM encoding recovers to IDLE.
// TESTING
//   Reset: hold reset_n=0 mid-RUN -> o_valid=0, o_busy=0, o_round=0, o_state=0 immediately; o_ready=1.
//   p12 with real add/sub/diffusion loopback, i_state=ASCON-128 IV||K||N test vector, i_rounds=12 ->
//     o_round 0..11 over 12 cycles, o_valid after 12 cycles, o_state matches reference model.
//   i_rounds=6, identity datapath (i_round_state=o_state) -> o_round 6,7,8,9,10,11; o_valid after 6.
//   i_rounds=0 and i_rounds=15 -> 12 rounds executed (o_round starts at 0).
//   Backpressure: i_ready=0 for 20 cycles in DONE -> o_state/o_valid stable; i_start pulses ignored;
//     i_ready=1 -> IDLE next cycle, o_ready=1.
//   Back-to-back: i_ready=1 and i_start=1 tied high, i_rounds=8 -> o_valid pulse every 10 cycles.

Source files
------------

// File: rtl/round_sequencer.sv
// ============================================================================
// round_sequencer
//   Iterates the ASCON permutation p^N over an external combinational round
//   datapath. Holds the 320-bit state register, supplies the round index to
//   the constant-addition stage, captures the round output every cycle and
//   presents the finished result with a valid/ready handshake.
//   Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pkg;

  // One 64-bit lane per ASCON state word; index 0 is x0.
  typedef logic [4:0][63:0] t_state_array;

  // Round constants of the 12-round schedule, index 0 first (0xf0 .. 0x4b).
  localparam logic [11:0][7:0] ROUND_CONSTANTS = {
    8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
    8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
  };

  localparam int NUM_ROUNDS = $bits(ROUND_CONSTANTS) / 8;

endpackage

module round_sequencer #(
  parameter int MAX_ROUNDS     = ascon_pkg::NUM_ROUNDS,
  parameter int DEFAULT_ROUNDS = 12
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    i_start,
  input  logic [3:0]              i_rounds,
  input  ascon_pkg::t_state_array i_state,
  output logic                    o_ready,
  output logic [3:0]              o_round,
  output ascon_pkg::t_state_array o_state,
  input  ascon_pkg::t_state_array i_round_state,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy
);

  // Round bookkeeping constants, sized to the 4-bit round index.
  localparam logic [4:0] MAX_ROUNDS_W5 = 5'(MAX_ROUNDS);
  localparam logic [3:0] MAX_ROUNDS_W4 = 4'(MAX_ROUNDS);
  localparam logic [3:0] DEFAULT_W4    = 4'(DEFAULT_ROUNDS);
  localparam logic [3:0] LAST_ROUND    = 4'(MAX_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                  fsm_q;
  state_t                  fsm_d;
  logic [3:0]              round_q;
  logic [3:0]              round_d;
  ascon_pkg::t_state_array perm_q;
  ascon_pkg::t_state_array perm_d;

  logic [3:0]              rounds_eff;
  logic [3:0]              first_round;
  logic                    at_last_round;

  // Out-of-range round requests fall back to the default count, so the
  // starting index always lands inside the constant table.
  assign rounds_eff  = (i_rounds == 4'd0 || {1'b0, i_rounds} > MAX_ROUNDS_W5)
                     ? DEFAULT_W4 : i_rounds;
  assign first_round = MAX_ROUNDS_W4 - rounds_eff;

  // Treat any index at or beyond the last one as final so a corrupted
  // counter can never walk past the end of the schedule.
  assign at_last_round = (round_q >= LAST_ROUND);

  // Next-state, round index and state-register update.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    perm_d  = perm_q;
    case (fsm_q)
      IDLE: begin
        if (i_start) begin
          fsm_d   = RUN;
          perm_d  = i_state;
          round_d = first_round;
        end
      end
      RUN: begin
        perm_d = i_round_state;
        if (at_last_round) begin
          fsm_d   = DONE;
          round_d = 4'd0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        // Result is retained after hand-off; only the FSM moves on.
        if (i_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // Registers; reset aborts any run in flight and clears the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      perm_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      perm_q  <= perm_d;
    end
  end

  // Status flags decode straight from the state register, so they are
  // glitch-free and never depend on same-cycle inputs.
  assign o_ready = (fsm_q == IDLE);
  assign o_busy  = (fsm_q == RUN);
  assign o_valid = (fsm_q == DONE);
  assign o_round = round_q;
  assign o_state = perm_q;

endmodule

`default_nettype wire
